i2c_reg_slave: RTL and testbench
================================

# i2c_reg_slave

I2C target (slave) that exposes a byte-addressed register space to an external I2C master. It matches a 7-bit chip address and decodes write and read transactions. It drives a simple synchronous register/RAM port: `reg_addr`, `data_out`/`write_en` for writes, and `data_in` for reads. It sits between the board I2C pins, through pad tri-state logic, and a local register file or single-port RAM whose enable is tied to `busy`.

## Interface
- `ADDR_BYTES`, default 1: number of register-address bytes per transaction, MSB first.
- `DATA_BYTES`, default 1: number of data bytes per register access, MSB first.
- `clk` in 1: system clock, 50 MHz nominal. All logic is on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `open_drain` in 1: 1 selects open-drain SDA, 0 selects push-pull SDA.
- `chip_addr` in 7: the I2C address this target answers to.
- `reg_addr` out 8*ADDR_BYTES: register pointer. It holds its value after STOP.
- `data_in` in 8*DATA_BYTES: read data from the register file. The register file has a 1-cycle synchronous latency.
- `write_en` out 1: one-cycle write strobe.
- `data_out` out 8*DATA_BYTES: write data, valid while `write_en` is high.
- `done` out 1: one-cycle pulse at STOP ending an addressed transaction.
- `busy` out 1: high from address match until STOP.
- `sda_in`, `scl_in` in 1: bus line levels.
- `sda_out`, `sda_oen` out 1: SDA data and enable. `sda_oen` is active-low (0 = drive).
- `scl_out`, `scl_oen` out 1: constant 1. No clock stretching.

## Operation
- Input conditioning:
  - `sda_in` and `scl_in` pass through 2-flop synchronizers.
  - SCL rise/fall and SDA edges are detected on the synchronized copies.
- Bus conditions, both checked in any state:
  - START or repeated START is SDA falling while SCL is high. It goes to ADDR.
  - STOP is SDA rising while SCL is high. It goes to IDLE.
- Bit handling:
  - Bits are sampled on SCL rise.
  - The slave changes SDA only after SCL fall.
- States:
  - IDLE.
  - ADDR: shift 8 bits. On match with `chip_addr`, go to ADDR_ACK and assert `busy`. On mismatch, go to WAIT_STOP with SDA released (NAK).
  - ADDR_ACK: drive 0 for the 9th clock.
    - R/W=0 goes to REG.
    - R/W=1 goes to RDATA. `data_in` is loaded into the shift register at the ACK-clock SCL fall, and its MSB is driven.
  - REG / REG_ACK: repeat for ADDR_BYTES bytes, then load `reg_addr`. After the ACK, go to WDATA.
  - WDATA / WDATA_ACK: repeat for DATA_BYTES bytes. After the last ACK, pulse `write_en` one cycle with `data_out` valid, then go to WAIT_STOP.
  - RDATA / RDATA_ACK:
    - Shift out DATA_BYTES bytes.
    - During the master's ACK/NAK clock, SDA is released.
    - After the last byte, SDA stays released whether the master sent ACK or NAK. Go to WAIT_STOP.
  - WAIT_STOP: SDA released. Further bytes in the transaction are NAKed.
  - One register access is made per transaction. There is no auto-increment.
- Reads use the pointer from the last write transaction. The pointer can be set by a write with address bytes only, followed by STOP, then START with addr+R.
- SDA output:
  - `open_drain`=1: `sda_out`=0. `sda_oen`=0 to drive low, 1 to release.
  - `open_drain`=0: `sda_oen`=0 in every slave-driving phase and 1 otherwise. `sda_out` carries the bit.

## Timing
- Reset values:
  - `sda_oen`=1, `sda_out`=0.
  - `scl_oen`=1, `scl_out`=1.
  - `write_en`=0, `done`=0, `busy`=0.
  - `reg_addr`=0, `data_out`=0.
  - State is IDLE.
- Reset mid-transaction releases SDA immediately and returns to IDLE.
- Latencies:
  - SDA update: ≤4 clk cycles after the physical SCL fall.
  - START/STOP detect: ≤3 cycles.
- `write_en`: asserted ≤4 cycles after the SCL fall ending the last data ACK. Exactly 1 cycle wide.
- `done`: 1 cycle, ≤3 cycles after STOP. `busy` falls in the same cycle.
- `data_in` is sampled at the ACK SCL fall. `reg_addr` is stable and `busy` has been high ≥2 cycles before that point.
- Minimum SCL high or low time: 6 clk cycles.

## Structure
- Shared package holds:
  - the FSM state enum;
  - the R/W bit constants.
- Sub-module `i2c_sync_edge` handles synchronizers and edge/START/STOP detection.

## Test plan
- Write 0x25 to reg 0x01 at chip 0x2C:
  - three ACKs;
  - one `write_en` pulse with `reg_addr`=0x01 and `data_out`=0x25;
  - `done` pulse.
- Pointer write of 0x01, STOP, START with addr+R, master ACK, STOP:
  - returns 0x25;
  - SDA released after the byte so STOP is detected.
- Address 0x2D: NAK, `busy` and `write_en` stay 0, no `done`.
- Repeated START (no STOP) between the pointer write and the read phase: returns correct data.
- Reset asserted mid-byte: all outputs go to reset values and SDA is released. The next full write succeeds.
- `open_drain`=0: `sda_oen`=0 only during ACK and read-data bits. `sda_out` matches the bits of 0x25.

Source files
------------

// File: rtl/i2c_reg_slave_pkg.sv
// ---------------------------------------------------------------------------
// i2c_reg_slave_pkg
// Shared definitions for the I2C register target: the protocol FSM state
// encoding and the meaning of the R/W bit that ends the address byte.
// ---------------------------------------------------------------------------
package i2c_reg_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Bit counter value once a full byte has been clocked on SCL rises
  localparam logic [3:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_reg_slave_sync_edge.sv
// ---------------------------------------------------------------------------
// i2c_sync_edge
// Brings the asynchronous SDA/SCL bus levels into the clk domain through
// two-flop synchronizers, keeps one extra delayed copy of each, and derives
// SCL edges plus START / STOP bus conditions from the synchronized copies.
//
// Ports
//   clk, reset       : system clock, asynchronous active-high reset
//   sda_in, scl_in   : raw bus line levels
//   sda_s            : synchronized SDA level
//   scl_rise/fall    : one-cycle pulses on synchronized SCL edges
//   start_det        : SDA fell while SCL high (START or repeated START)
//   stop_det         : SDA rose while SCL high (STOP)
// ---------------------------------------------------------------------------
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sda_in,
  input  logic scl_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic sda_p0_q, sda_p1_q, sda_p2_q;
  logic sda_p0_d, sda_p1_d, sda_p2_d;
  logic scl_p0_q, scl_p1_q, scl_p2_q;
  logic scl_p0_d, scl_p1_d, scl_p2_d;

  always_comb begin
    sda_p0_d = sda_in;
    sda_p1_d = sda_p0_q;
    sda_p2_d = sda_p1_q;
    scl_p0_d = scl_in;
    scl_p1_d = scl_p0_q;
    scl_p2_d = scl_p1_q;
  end

  // Reset to the idle bus level so leaving reset never fakes a condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_p0_q <= 1'b1;
      sda_p1_q <= 1'b1;
      sda_p2_q <= 1'b1;
      scl_p0_q <= 1'b1;
      scl_p1_q <= 1'b1;
      scl_p2_q <= 1'b1;
    end else begin
      sda_p0_q <= sda_p0_d;
      sda_p1_q <= sda_p1_d;
      sda_p2_q <= sda_p2_d;
      scl_p0_q <= scl_p0_d;
      scl_p1_q <= scl_p1_d;
      scl_p2_q <= scl_p2_d;
    end
  end

  // _p1 is the synchronized level, _p2 the same level one cycle earlier
  assign sda_s     = sda_p1_q;
  assign scl_rise  = scl_p1_q & ~scl_p2_q;
  assign scl_fall  = ~scl_p1_q & scl_p2_q;
  assign start_det = scl_p1_q & scl_p2_q & sda_p2_q & ~sda_p1_q;
  assign stop_det  = scl_p1_q & scl_p2_q & ~sda_p2_q & sda_p1_q;

endmodule

// File: rtl/i2c_reg_slave.sv
// ---------------------------------------------------------------------------
// i2c_reg_slave
// I2C target exposing a byte-addressed register space. A write transaction
// carries ADDR_BYTES pointer bytes then DATA_BYTES data bytes (MSB first) and
// ends in a single write_en strobe. A read transaction returns DATA_BYTES
// bytes from the pointer left by the last write. No clock stretching.
//
// Ports
//   clk, reset            : system clock, asynchronous active-high reset
//   open_drain            : 1 = open-drain SDA, 0 = push-pull SDA
//   chip_addr             : 7-bit bus address this target answers to
//   reg_addr              : register pointer (holds after STOP)
//   data_in               : register read data, 1-cycle synchronous latency
//   write_en, data_out    : one-cycle write strobe and its data
//   done                  : pulse at STOP ending an addressed transaction
//   busy                  : high from address match until STOP
//   sda_in, scl_in        : bus line levels
//   sda_out, sda_oen      : SDA value and active-low output enable
//   scl_out, scl_oen      : tied high (SCL never driven)
// ---------------------------------------------------------------------------
module i2c_reg_slave
  import i2c_reg_slave_pkg::*;
#(
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    open_drain,
  input  logic [6:0]              chip_addr,
  output logic [8*ADDR_BYTES-1:0] reg_addr,
  input  logic [8*DATA_BYTES-1:0] data_in,
  output logic                    write_en,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    done,
  output logic                    busy,
  input  logic                    sda_in,
  input  logic                    scl_in,
  output logic                    sda_out,
  output logic                    sda_oen,
  output logic                    scl_out,
  output logic                    scl_oen
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .sda_in    (sda_in),
    .scl_in    (scl_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rw_q, rw_d;
  logic          mack_q, mack_d;
  logic [AW-1:0] addr_acc_q, addr_acc_d;
  logic [DW-1:0] data_acc_q, data_acc_d;
  logic [DW-1:0] rd_sh_q, rd_sh_d;
  logic [AW-1:0] reg_addr_q, reg_addr_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          write_en_q, write_en_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          drive_q, drive_d;
  logic          sda_bit_q, sda_bit_d;

  logic          rx_state;
  logic          byte_end;
  logic          last_addr_byte;
  logic          last_data_byte;

  always_comb begin
    rx_state       = (state_q == ST_ADDR) || (state_q == ST_REG) ||
                     (state_q == ST_WDATA);
    byte_end       = scl_fall && (bit_cnt_q == BYTE_BITS);
    last_addr_byte = (byte_cnt_q == 8'(ADDR_BYTES - 1));
    last_data_byte = (byte_cnt_q == 8'(DATA_BYTES - 1));
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    addr_acc_d = addr_acc_q;
    data_acc_d = data_acc_q;
    rd_sh_d    = rd_sh_q;
    reg_addr_d = reg_addr_q;
    data_out_d = data_out_q;
    write_en_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    drive_d    = drive_q;
    sda_bit_d  = sda_bit_q;

    // Bus conditions override whatever byte phase we think we are in
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      drive_d   = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      drive_d   = 1'b0;
      done_d    = busy_q;
      busy_d    = 1'b0;
    end else begin
      if (rx_state && scl_rise) begin
        shreg_d   = {shreg_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end

      unique case (state_q)
        ST_ADDR: begin
          if (byte_end) begin
            bit_cnt_d = 4'd0;
            if (shreg_q[7:1] == chip_addr) begin
              state_d   = ST_ADDR_ACK;
              rw_d      = shreg_q[0];
              busy_d    = 1'b1;
              drive_d   = 1'b1;
              sda_bit_d = 1'b0;
            end else begin
              state_d   = ST_WAIT_STOP;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d  = 4'd0;
            byte_cnt_d = 8'd0;
            if (rw_q == RW_READ) begin
              // data_in already reflects reg_addr, which has been stable
              // since well before the address byte finished
              rd_sh_d   = data_in;
              drive_d   = 1'b1;
              sda_bit_d = data_in[DW-1];
              state_d   = ST_RDATA;
            end else begin
              drive_d   = 1'b0;
              state_d   = ST_REG;
            end
          end
        end

        ST_REG: begin
          if (byte_end) begin
            bit_cnt_d  = 4'd0;
            addr_acc_d = (addr_acc_q << 8) | AW'(shreg_q);
            drive_d    = 1'b1;
            sda_bit_d  = 1'b0;
            state_d    = ST_REG_ACK;
          end
        end

        ST_REG_ACK: begin
          if (scl_fall) begin
            drive_d = 1'b0;
            if (last_addr_byte) begin
              reg_addr_d = addr_acc_q;
              byte_cnt_d = 8'd0;
              state_d    = ST_WDATA;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              state_d    = ST_REG;
            end
          end
        end

        ST_WDATA: begin
          if (byte_end) begin
            bit_cnt_d  = 4'd0;
            data_acc_d = (data_acc_q << 8) | DW'(shreg_q);
            drive_d    = 1'b1;
            sda_bit_d  = 1'b0;
            state_d    = ST_WDATA_ACK;
          end
        end

        ST_WDATA_ACK: begin
          if (scl_fall) begin
            drive_d = 1'b0;
            if (last_data_byte) begin
              write_en_d = 1'b1;
              data_out_d = data_acc_q;
              state_d    = ST_WAIT_STOP;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              state_d    = ST_WDATA;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && (bit_cnt_q != 4'd0)) begin
            rd_sh_d = rd_sh_q << 1;
            if (bit_cnt_q == BYTE_BITS) begin
              // Master owns SDA for its ACK/NAK bit
              drive_d   = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RDATA_ACK;
            end else begin
              sda_bit_d = rd_sh_q[DW-2];
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            mack_d = ~sda_s;
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (last_data_byte || !mack_q) begin
              state_d = ST_WAIT_STOP;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              drive_d    = 1'b1;
              sda_bit_d  = rd_sh_q[DW-1];
              state_d    = ST_RDATA;
            end
          end
        end

        default: begin
          // IDLE and WAIT_STOP: SDA stays released, only bus conditions act
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 8'd0;
      shreg_q    <= 8'd0;
      rw_q       <= RW_WRITE;
      mack_q     <= 1'b0;
      addr_acc_q <= '0;
      data_acc_q <= '0;
      rd_sh_q    <= '0;
      reg_addr_q <= '0;
      data_out_q <= '0;
      write_en_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      drive_q    <= 1'b0;
      sda_bit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      addr_acc_q <= addr_acc_d;
      data_acc_q <= data_acc_d;
      rd_sh_q    <= rd_sh_d;
      reg_addr_q <= reg_addr_d;
      data_out_q <= data_out_d;
      write_en_q <= write_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      drive_q    <= drive_d;
      sda_bit_q  <= sda_bit_d;
    end
  end

  // Open-drain can only pull low, so a '1' bit becomes a release;
  // push-pull enables the driver for the whole slave-owned bit
  assign sda_oen  = open_drain ? ~(drive_q & ~sda_bit_q) : ~drive_q;
  assign sda_out  = open_drain ? 1'b0 : (drive_q & sda_bit_q);
  assign scl_out  = 1'b1;
  assign scl_oen  = 1'b1;

  assign reg_addr = reg_addr_q;
  assign data_out = data_out_q;
  assign write_en = write_en_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_slave
// Bit-level I2C master driving i2c_reg_slave at chip address 0x2C, with a
// behavioural register file (1-cycle read latency) behind the register port.
// ---------------------------------------------------------------------------
module tb_i2c_reg_slave;

  localparam int T = 4; // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       open_drain;
  logic [6:0] chip_addr;
  logic [7:0] reg_addr;
  logic [7:0] data_in;
  logic       write_en;
  logic [7:0] data_out;
  logic       done;
  logic       busy;
  logic       sda_out, sda_oen, scl_out, scl_oen;
  logic       sda_m, scl_m;
  logic       sda_line;

  int vectors     = 0;
  int miscompares = 0;
  int drive_conflicts = 0;

  int we_cnt = 0, done_cnt = 0, busy_cycles = 0, we_run = 0, we_max = 0;
  logic [7:0] cap_addr = 8'h00, cap_data = 8'h00;

  always #10 clk = ~clk;

  assign sda_line = sda_m & (sda_oen ? 1'b1 : sda_out);

  i2c_reg_slave #(.ADDR_BYTES(1), .DATA_BYTES(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .open_drain (open_drain),
    .chip_addr  (chip_addr),
    .reg_addr   (reg_addr),
    .data_in    (data_in),
    .write_en   (write_en),
    .data_out   (data_out),
    .done       (done),
    .busy       (busy),
    .sda_in     (sda_line),
    .scl_in     (scl_m),
    .sda_out    (sda_out),
    .sda_oen    (sda_oen),
    .scl_out    (scl_out),
    .scl_oen    (scl_oen)
  );

  // Register file: unwritten locations read as addr ^ 0xA5
  logic [7:0] ram [256];
  logic       ram_vld [256];
  always @(posedge clk) begin
    if (write_en === 1'b1) begin
      ram[reg_addr]     <= data_out;
      ram_vld[reg_addr] <= 1'b1;
    end
    data_in <= (ram_vld[reg_addr] === 1'b1) ? ram[reg_addr] : (reg_addr ^ 8'hA5);
  end

  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      we_cnt   = we_cnt + 1;
      cap_addr = reg_addr;
      cap_data = data_out;
      we_run   = we_run + 1;
      if (we_run > we_max) we_max = we_run;
    end else begin
      we_run = 0;
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (busy === 1'b1) busy_cycles = busy_cycles + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(T);
    scl_m = 1'b1; wait_clk(T);
    sda_m = 1'b0; wait_clk(T);
    scl_m = 1'b0; wait_clk(T);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(T);
    scl_m = 1'b1; wait_clk(T);
    sda_m = 1'b1; wait_clk(2*T);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(T);
    sda_m = b;
    wait_clk(T);
    scl_m = 1'b1;
    wait_clk(T);
    if (sda_oen === 1'b0) drive_conflicts = drive_conflicts + 1;
    wait_clk(T);
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b, output logic oen, output logic o);
    sda_m = 1'b1;
    wait_clk(2*T);
    scl_m = 1'b1;
    wait_clk(T);
    b   = sda_line;
    oen = sda_oen;
    o   = sda_out;
    wait_clk(T);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack,
                            output logic ack_oen, output logic ack_out);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    read_bit(b, ack_oen, ack_out);
    ack = ~b;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] v,
                           output logic [7:0] oen_v, output logic [7:0] out_v);
    for (int i = 7; i >= 0; i--) read_bit(v[i], oen_v[i], out_v[i]);
    send_bit(~mack);
  endtask

  task automatic test_reset();
    reset = 1'b1; sda_m = 1'b1; scl_m = 1'b1;
    open_drain = 1'b1; chip_addr = 7'h2C;
    wait_clk(5);
    vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL reset_sda_oen got %b want 1", sda_oen); end
    vectors++; if (sda_out !== 1'b0) begin miscompares++; $display("FAIL reset_sda_out got %b want 0", sda_out); end
    vectors++; if ({scl_oen, scl_out} !== 2'b11) begin miscompares++; $display("FAIL reset_scl got %b want 11", {scl_oen, scl_out}); end
    vectors++; if ({write_en, done, busy} !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl got %b want 000", {write_en, done, busy}); end
    vectors++; if (reg_addr !== 8'h00) begin miscompares++; $display("FAIL reset_reg_addr got %h want 00", reg_addr); end
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out got %h want 00", data_out); end
    reset = 1'b0;
    wait_clk(5);
  endtask

  task automatic full_write(input logic [7:0] ra, input logic [7:0] d, input string nm);
    logic a0, a1, a2, ao, av;
    int we0, dn0;
    we0 = we_cnt; dn0 = done_cnt;
    bus_start();
    write_byte(8'h58, a0, ao, av);
    write_byte(ra, a1, ao, av);
    write_byte(d, a2, ao, av);
    bus_stop();
    wait_clk(4);
    vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL %s_acks got %b want 111", nm, {a0, a1, a2}); end
    vectors++; if (we_cnt - we0 !== 1) begin miscompares++; $display("FAIL %s_we_count got %0d want 1", nm, we_cnt - we0); end
    vectors++; if (cap_addr !== ra) begin miscompares++; $display("FAIL %s_we_addr got %h want %h", nm, cap_addr, ra); end
    vectors++; if (cap_data !== d) begin miscompares++; $display("FAIL %s_we_data got %h want %h", nm, cap_data, d); end
    vectors++; if (done_cnt - dn0 !== 1) begin miscompares++; $display("FAIL %s_done got %0d want 1", nm, done_cnt - dn0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_after got %b want 0", nm, busy); end
  endtask

  task automatic test_write();
    full_write(8'h01, 8'h25, "write");
    vectors++; if (reg_addr !== 8'h01) begin miscompares++; $display("FAIL write_reg_addr_hold got %h want 01", reg_addr); end
    vectors++; if (drive_conflicts !== 0) begin miscompares++; $display("FAIL write_master_bits_driven got %0d want 0", drive_conflicts); end
  endtask

  task automatic test_read();
    logic a0, a1, a2, ao, av;
    logic [7:0] v, ov, dv;
    int dn0;
    dn0 = done_cnt;
    bus_start();
    write_byte(8'h58, a0, ao, av);
    write_byte(8'h01, a1, ao, av);
    bus_stop();
    bus_start();
    write_byte(8'h59, a2, ao, av);
    read_byte(1'b1, v, ov, dv);
    bus_stop();
    wait_clk(4);
    vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL read_acks got %b want 111", {a0, a1, a2}); end
    vectors++; if (v !== 8'h25) begin miscompares++; $display("FAIL read_data got %h want 25", v); end
    vectors++; if (done_cnt - dn0 !== 2) begin miscompares++; $display("FAIL read_done got %0d want 2", done_cnt - dn0); end
    vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL read_sda_released got %b want 1", sda_oen); end
  endtask

  task automatic test_nak();
    logic a0, ao, av;
    int we0, dn0, bc0;
    we0 = we_cnt; dn0 = done_cnt; bc0 = busy_cycles;
    bus_start();
    write_byte(8'h5A, a0, ao, av);
    bus_stop();
    wait_clk(4);
    vectors++; if (a0 !== 1'b0) begin miscompares++; $display("FAIL nak_ack got %b want 0", a0); end
    vectors++; if (busy_cycles - bc0 !== 0) begin miscompares++; $display("FAIL nak_busy got %0d cycles want 0", busy_cycles - bc0); end
    vectors++; if (we_cnt - we0 !== 0) begin miscompares++; $display("FAIL nak_we got %0d want 0", we_cnt - we0); end
    vectors++; if (done_cnt - dn0 !== 0) begin miscompares++; $display("FAIL nak_done got %0d want 0", done_cnt - dn0); end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2, ao, av;
    logic [7:0] v, ov, dv;
    int dn0;
    full_write(8'h03, 8'h7E, "rs_setup");
    dn0 = done_cnt;
    bus_start();
    write_byte(8'h58, a0, ao, av);
    write_byte(8'h03, a1, ao, av);
    bus_start();
    write_byte(8'h59, a2, ao, av);
    read_byte(1'b0, v, ov, dv);
    bus_stop();
    wait_clk(4);
    vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL rs_acks got %b want 111", {a0, a1, a2}); end
    vectors++; if (v !== 8'h7E) begin miscompares++; $display("FAIL rs_data got %h want 7e", v); end
    vectors++; if (done_cnt - dn0 !== 1) begin miscompares++; $display("FAIL rs_done got %0d want 1", done_cnt - dn0); end
  endtask

  task automatic test_reset_mid();
    logic a0, ao, av;
    bus_start();
    write_byte(8'h59, a0, ao, av);
    wait_clk(6);
    // reg 0x03 holds 0x7E, so the slave is pulling SDA low for bit 7
    vectors++; if (sda_oen !== 1'b0) begin miscompares++; $display("FAIL mid_pre_drive got %b want 0", sda_oen); end
    reset = 1'b1;
    #1;
    vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL mid_sda_oen got %b want 1", sda_oen); end
    vectors++; if ({sda_out, scl_oen, scl_out} !== 3'b011) begin miscompares++; $display("FAIL mid_outs got %b want 011", {sda_out, scl_oen, scl_out}); end
    vectors++; if ({write_en, done, busy} !== 3'b000) begin miscompares++; $display("FAIL mid_ctrl got %b want 000", {write_en, done, busy}); end
    vectors++; if ({reg_addr, data_out} !== 16'h0000) begin miscompares++; $display("FAIL mid_regs got %h want 0000", {reg_addr, data_out}); end
    wait_clk(3);
    reset = 1'b0;
    wait_clk(3);
    bus_stop();
    full_write(8'h05, 8'h42, "post_reset");
  endtask

  task automatic test_push_pull();
    logic a0, a1, a2, ao0, ao1, ao2, av0, av1, av2, ao, av;
    logic [7:0] v, ov, dv;
    int dc0;
    open_drain = 1'b0;
    dc0 = drive_conflicts;
    bus_start();
    write_byte(8'h58, a0, ao0, av0);
    write_byte(8'h06, a1, ao1, av1);
    write_byte(8'h25, a2, ao2, av2);
    bus_stop();
    vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL pp_acks got %b want 111", {a0, a1, a2}); end
    vectors++; if ({ao0, ao1, ao2, av0, av1, av2} !== 6'b000000) begin miscompares++; $display("FAIL pp_ack_drive got %b want 000000", {ao0, ao1, ao2, av0, av1, av2}); end
    bus_start();
    write_byte(8'h59, a0, ao, av);
    read_byte(1'b0, v, ov, dv);
    bus_stop();
    wait_clk(4);
    vectors++; if (v !== 8'h25) begin miscompares++; $display("FAIL pp_read_data got %h want 25", v); end
    vectors++; if (ov !== 8'h00) begin miscompares++; $display("FAIL pp_read_oen got %b want 00000000", ov); end
    vectors++; if (dv !== 8'h25) begin miscompares++; $display("FAIL pp_sda_out_bits got %b want 00100101", dv); end
    vectors++; if (drive_conflicts - dc0 !== 0) begin miscompares++; $display("FAIL pp_master_bits_driven got %0d want 0", drive_conflicts - dc0); end
    vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL pp_idle_oen got %b want 1", sda_oen); end
    vectors++; if (we_max !== 1) begin miscompares++; $display("FAIL we_width got %0d want 1", we_max); end
    open_drain = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_repeated_start();
    test_reset_mid();
    test_push_pull();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
